sel_pipe_stage: RTL and testbench

//  Registered N-way result selector for the float_adder datapath, with a valid/ready

---
 rtl/float_adder_pkg.sv | 22 ++
 rtl/pipe_skid_buf.sv | 87 ++++++++
 rtl/sel_pipe_stage.sv | 66 ++++++
 tb/tb_sel_pipe_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/float_adder_pkg.sv
// float_adder_pkg
//   Shared constants and types for the float_adder datapath.
//   FRAC_W       : default fraction/candidate word width
//   SEL_*        : candidate indices for the standard result selector inputs
//   skid_act_e   : per-edge update chosen by the 2-entry skid buffer
package float_adder_pkg;

  localparam int unsigned FRAC_W = 28;

  localparam int unsigned SEL_BIG_ALU = 0;
  localparam int unsigned SEL_FRA     = 1;
  localparam int unsigned SEL_SHIFT   = 2;

  typedef enum logic [2:0] {
    SKID_HOLD,        // nothing moves
    SKID_LOAD_MAIN,   // incoming beat written to main (main empty or being drained)
    SKID_PROMOTE,     // main drained, skid entry moves up into main
    SKID_EMPTY_MAIN,  // main drained, nothing to refill it
    SKID_LOAD_SKID    // main stalled, incoming beat parked in skid
  } skid_act_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf
//   Generic 2-entry valid/ready skid buffer. The main entry drives the outputs
//   directly; the skid entry absorbs one beat while downstream stalls.
//   in_ready is a pure flop output, so out_ready never reaches upstream
//   combinationally.
// Ports
//   clk       in   clock, rising edge
//   res       in   synchronous active-high reset
//   in_valid  in   upstream beat present
//   in_ready  out  buffer can accept a beat this cycle
//   in_data   in   WIDTH beat payload
//   out_valid out  main entry holds a beat
//   out_ready in   downstream accepts this cycle
//   out_data  out  WIDTH main entry payload
module pipe_skid_buf
  import float_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 29
) (
  input  logic             clk,
  input  logic             res,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_v;
  logic             skid_v;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_d;
  logic             accept;
  logic             drain;
  skid_act_e        act;

  assign in_ready  = !skid_v;
  assign out_valid = main_v;
  assign out_data  = main_d;

  assign accept = in_valid && !skid_v;
  assign drain  = main_v && out_ready;

  always_comb begin
    act = SKID_HOLD;
    if (!main_v) begin
      if (accept) act = SKID_LOAD_MAIN;
    end else if (drain) begin
      // skid full implies accept is low, so promotion never races a new beat
      if (skid_v)      act = SKID_PROMOTE;
      else if (accept) act = SKID_LOAD_MAIN;
      else             act = SKID_EMPTY_MAIN;
    end else if (accept) begin
      act = SKID_LOAD_SKID;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else begin
      case (act)
        SKID_LOAD_MAIN: begin
          main_v <= 1'b1;
          main_d <= in_data;
        end
        SKID_PROMOTE: begin
          main_d <= skid_d;
          skid_v <= 1'b0;
        end
        SKID_EMPTY_MAIN: begin
          main_v <= 1'b0;
        end
        SKID_LOAD_SKID: begin
          skid_v <= 1'b1;
          skid_d <= in_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sel_pipe_stage.sv
// sel_pipe_stage
//   Registered NUM_IN-way result selector for the float_adder datapath with a
//   valid/ready handshake and a 2-entry skid buffer. The chosen candidate and an
//   out-of-range flag are captured with the beat and emitted one cycle later.
// Ports
//   clk       in   clock, rising edge
//   res       in   synchronous active-high reset
//   in_valid  in   upstream beat present
//   in_ready  out  stage can accept a beat this cycle
//   sel       in   SEL_W candidate index for this beat
//   in_data   in   NUM_IN*WIDTH packed candidates, word k at [k*WIDTH +: WIDTH]
//   out_valid out  output beat present
//   out_ready in   downstream accepts this cycle
//   out_data  out  WIDTH selected word (0 when sel out of range)
//   out_err   out  beat had sel >= NUM_IN
module sel_pipe_stage
  import float_adder_pkg::*;
#(
  parameter  int unsigned WIDTH  = FRAC_W,
  parameter  int unsigned NUM_IN = 2,
  localparam int unsigned SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err
);

  logic [WIDTH-1:0] sel_word;
  logic             sel_err;
  logic [WIDTH:0]   buf_out;

  always_comb begin
    sel_word = '0;
    sel_err  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (32'(sel) == k) begin
        sel_word = in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  pipe_skid_buf #(
    .WIDTH(WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .res      (res),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({sel_err, sel_word}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (buf_out)
  );

  assign out_err  = buf_out[WIDTH];
  assign out_data = buf_out[WIDTH-1:0];

endmodule

// File: tb/tb_sel_pipe_stage.sv
module tb_sel_pipe_stage;

  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // DUT A: WIDTH 28, NUM_IN 2
  logic        a_in_valid = 1'b0, a_in_ready, a_sel = 1'b0;
  logic [55:0] a_in_data = '0;
  logic        a_out_valid, a_out_ready = 1'b1, a_out_err;
  logic [27:0] a_out_data;
  // DUT B: WIDTH 28, NUM_IN 3
  logic        b_in_valid = 1'b0, b_in_ready;
  logic [1:0]  b_sel = '0;
  logic [83:0] b_in_data = '0;
  logic        b_out_valid, b_out_ready = 1'b1, b_out_err;
  logic [27:0] b_out_data;
  // DUT C: WIDTH 32, NUM_IN 4
  logic         c_in_valid = 1'b0, c_in_ready;
  logic [1:0]   c_sel = '0;
  logic [127:0] c_in_data = '0;
  logic         c_out_valid, c_out_ready = 1'b1, c_out_err;
  logic [31:0]  c_out_data;

  sel_pipe_stage #(.WIDTH(28), .NUM_IN(2)) dut_a (
    .clk(clk), .res(res), .in_valid(a_in_valid), .in_ready(a_in_ready), .sel(a_sel),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_err(a_out_err));

  sel_pipe_stage #(.WIDTH(28), .NUM_IN(3)) dut_b (
    .clk(clk), .res(res), .in_valid(b_in_valid), .in_ready(b_in_ready), .sel(b_sel),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_err(b_out_err));

  sel_pipe_stage #(.WIDTH(32), .NUM_IN(4)) dut_c (
    .clk(clk), .res(res), .in_valid(c_in_valid), .in_ready(c_in_ready), .sel(c_sel),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_err(c_out_err));

  // expected {err, data} per emitted beat
  logic [32:0] qa[$];
  logic [32:0] qb[$];
  logic [32:0] qc[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [32:0] e28(input logic err, input logic [27:0] d);
    return {4'b0, err, d};
  endfunction

  // ---------------- monitors: sample 1 time unit after the falling edge
  logic        a_stall = 1'b0, b_stall = 1'b0, c_stall = 1'b0;
  logic [32:0] a_held, b_held, c_held;

  always @(negedge clk) begin
    #1;
    if (res === 1'b0 && a_out_valid === 1'b1) begin
      if (a_out_ready) begin
        if (qa.size() == 0) begin
          checks++;
          $display("FAIL a_extra_beat: got %h expected no beat at %0t", {a_out_err, a_out_data}, $time);
        end else chk("a_beat", 64'({a_out_err, a_out_data}), 64'(qa.pop_front()));
      end else if (a_stall) chk("a_stall_hold", 64'({a_out_err, a_out_data}), 64'(a_held));
      a_stall = !a_out_ready;
      a_held  = e28(a_out_err, a_out_data);
    end else a_stall = 1'b0;
  end

  always @(negedge clk) begin
    #1;
    if (res === 1'b0 && b_out_valid === 1'b1) begin
      if (b_out_ready) begin
        if (qb.size() == 0) begin
          checks++;
          $display("FAIL b_extra_beat: got %h expected no beat at %0t", {b_out_err, b_out_data}, $time);
        end else chk("b_beat", 64'({b_out_err, b_out_data}), 64'(qb.pop_front()));
      end else if (b_stall) chk("b_stall_hold", 64'({b_out_err, b_out_data}), 64'(b_held));
      b_stall = !b_out_ready;
      b_held  = e28(b_out_err, b_out_data);
    end else b_stall = 1'b0;
  end

  always @(negedge clk) begin
    #1;
    if (res === 1'b0 && c_out_valid === 1'b1) begin
      if (c_out_ready) begin
        if (qc.size() == 0) begin
          checks++;
          $display("FAIL c_extra_beat: got %h expected no beat at %0t", {c_out_err, c_out_data}, $time);
        end else chk("c_beat", 64'({c_out_err, c_out_data}), 64'(qc.pop_front()));
      end else if (c_stall) chk("c_stall_hold", 64'({c_out_err, c_out_data}), 64'(c_held));
      c_stall = !c_out_ready;
      c_held  = {c_out_err, c_out_data};
    end else c_stall = 1'b0;
  end

  // ---------------- drivers: called on a falling edge, return on the falling edge after accept
  task automatic send_a(input logic s, input logic [55:0] d, input logic [32:0] exp);
    int unsigned n = 0;
    a_in_valid = 1'b1; a_sel = s; a_in_data = d;
    while (a_in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++;
      $display("FAIL a_accept_timeout: got in_ready=%b expected 1", a_in_ready);
    end else qa.push_back(exp);
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] s, input logic [83:0] d, input logic [32:0] exp);
    int unsigned n = 0;
    b_in_valid = 1'b1; b_sel = s; b_in_data = d;
    while (b_in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++;
      $display("FAIL b_accept_timeout: got in_ready=%b expected 1", b_in_ready);
    end else qb.push_back(exp);
    @(negedge clk);
    b_in_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [55:0]  d2;
    logic [83:0]  d3;
    logic         took;
    int unsigned  sent;
    logic [31:0]  w;

    // 1. reset held 2 cycles with a beat offered
    a_in_valid = 1'b1; a_in_data = 56'h123;
    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b0; a_in_valid = 1'b0;
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_data",  64'(a_out_data),  64'd0);
    chk("rst_out_err",   64'(a_out_err),   64'd0);
    chk("rst_in_ready",  64'(a_in_ready),  64'd1);
    @(negedge clk);
    chk("rst_no_beat", 64'(a_out_valid), 64'd0);

    // 2. streaming sel 0/1/0, one beat per cycle
    a_out_ready = 1'b1;
    d2 = {28'hABCDEF0, 28'h1234567};
    send_a(1'b0, d2, e28(1'b0, 28'h1234567));
    chk("stream_lat0", 64'(a_out_valid), 64'd1);
    send_a(1'b1, d2, e28(1'b0, 28'hABCDEF0));
    chk("stream_lat1", 64'(a_out_valid), 64'd1);
    send_a(1'b0, d2, e28(1'b0, 28'h1234567));
    chk("stream_lat2", 64'(a_out_valid), 64'd1);
    @(negedge clk);
    chk("stream_idle", 64'(a_out_valid), 64'd0);

    // 3. back-pressure fills main then skid
    a_out_ready = 1'b0;
    send_a(1'b0, {28'h0, 28'h11}, e28(1'b0, 28'h11));
    send_a(1'b0, {28'h0, 28'h22}, e28(1'b0, 28'h22));
    chk("bp_full_in_ready", 64'(a_in_ready), 64'd0);
    chk("bp_hold_data",     64'(a_out_data), 64'h11);
    repeat (2) @(negedge clk);
    chk("bp_hold_data2",    64'(a_out_data), 64'h11);
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_back", 64'(a_in_ready), 64'd1);
    chk("bp_second_data",   64'(a_out_data), 64'h22);
    @(negedge clk);
    chk("bp_drained", 64'(a_out_valid), 64'd0);

    // 5. reset while both entries are full
    a_out_ready = 1'b0;
    send_a(1'b0, {28'h0, 28'h33}, e28(1'b0, 28'h33));
    send_a(1'b1, {28'h44, 28'h0}, e28(1'b0, 28'h44));
    chk("mr_full", 64'(a_in_ready), 64'd0);
    res = 1'b1;
    qa.delete();
    @(negedge clk);
    res = 1'b0;
    chk("mr_out_valid", 64'(a_out_valid), 64'd0);
    chk("mr_in_ready",  64'(a_in_ready),  64'd1);
    chk("mr_out_data",  64'(a_out_data),  64'd0);
    a_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("mr_nothing", 64'(a_out_valid), 64'd0);
    send_a(1'b0, {28'h0, 28'h55}, e28(1'b0, 28'h55));
    @(negedge clk);

    // 4. out-of-range select on the 3-input instance
    d3 = {28'h300, 28'h200, 28'h100};
    b_out_ready = 1'b1;
    send_b(2'd3, d3, e28(1'b1, 28'h0));
    chk("bad_sel_err", 64'(b_out_err), 64'd1);
    send_b(2'd2, d3, e28(1'b0, 28'h300));
    chk("good_sel_err", 64'(b_out_err), 64'd0);
    send_b(2'd0, d3, e28(1'b0, 28'h100));
    @(negedge clk);

    // 6. random traffic on the 32-bit 4-input instance
    took = 1'b0;
    sent = 0;
    for (int cyc = 0; cyc < 20000 && sent < 2000; cyc++) begin
      c_out_ready = ($urandom_range(0, 3) != 0);
      if (!c_in_valid || took) begin
        if ($urandom_range(0, 3) != 0) begin
          c_in_valid = 1'b1;
          c_in_data  = {$urandom, $urandom, $urandom, $urandom};
          c_sel      = 2'($urandom_range(0, 3));
        end else c_in_valid = 1'b0;
      end
      took = c_in_valid && c_in_ready;
      if (took) begin
        w = c_in_data[c_sel*32 +: 32];
        qc.push_back({1'b0, w});
        sent++;
      end
      @(negedge clk);
    end
    c_in_valid = 1'b0;
    c_out_ready = 1'b1;
    chk("rand_sent", 64'(sent), 64'd2000);
    repeat (5) @(negedge clk);

    chk("a_queue_empty", 64'(qa.size()), 64'd0);
    chk("b_queue_empty", 64'(qb.size()), 64'd0);
    chk("c_queue_empty", 64'(qc.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
